// File: rtl/mist_video_outstage.sv
// Video output stage: realigns sync/blank with late colour data, learns sync
// polarity from measured duty cycle and registers active-low VGA outputs.
module mist_video_outstage #(
  parameter int COLOR_DEPTH = 6,
  parameter int SYNC_DELAY  = 3,
  parameter int HCNT_WIDTH  = 12,
  parameter int VCNT_WIDTH  = 11
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic [COLOR_DEPTH-1:0] R,
  input  logic [COLOR_DEPTH-1:0] G,
  input  logic [COLOR_DEPTH-1:0] B,
  input  logic                   HSync,
  input  logic                   VSync,
  input  logic                   HBlank,
  input  logic                   VBlank,
  input  logic                   csync_en,
  output logic [COLOR_DEPTH-1:0] VGA_R,
  output logic [COLOR_DEPTH-1:0] VGA_G,
  output logic [COLOR_DEPTH-1:0] VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_DE,
  output logic                   hs_pol,
  output logic                   vs_pol
);

  localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;
  localparam logic [VCNT_WIDTH-1:0] VCNT_MAX = '1;

  logic d_hs, d_vs, d_hb, d_vb;

  generate
    if (SYNC_DELAY == 0) begin : g_bypass
      assign d_hs = HSync;
      assign d_vs = VSync;
      assign d_hb = HBlank;
      assign d_vb = VBlank;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_sr, vs_sr, hb_sr, vb_sr;

      // blank stages come out of reset set, so the output stays black until refilled
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          hs_sr <= '0;
          vs_sr <= '0;
          hb_sr <= '1;
          vb_sr <= '1;
        end else begin
          hs_sr <= (hs_sr << 1) | SYNC_DELAY'(HSync);
          vs_sr <= (vs_sr << 1) | SYNC_DELAY'(VSync);
          hb_sr <= (hb_sr << 1) | SYNC_DELAY'(HBlank);
          vb_sr <= (vb_sr << 1) | SYNC_DELAY'(VBlank);
        end
      end

      assign d_hs = hs_sr[SYNC_DELAY-1];
      assign d_vs = vs_sr[SYNC_DELAY-1];
      assign d_hb = hb_sr[SYNC_DELAY-1];
      assign d_vb = vb_sr[SYNC_DELAY-1];
    end
  endgenerate

  logic                  hs_prev, vs_prev;
  logic                  hs_rise, vs_rise;
  logic                  hs_armed, vs_armed;
  logic [HCNT_WIDTH-1:0] hi_cnt, lo_cnt;
  logic [VCNT_WIDTH-1:0] vhi_cnt, vlo_cnt;

  assign hs_rise = HSync & ~hs_prev;
  assign vs_rise = VSync & ~vs_prev;

  // The first edge after reset only starts a measurement; a partial line
  // or frame must never produce a polarity decision.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      hs_armed <= 1'b0;
      hs_pol   <= 1'b0;
      hi_cnt   <= '0;
      lo_cnt   <= '0;
    end else begin
      hs_prev <= HSync;
      if (hs_rise) begin
        hi_cnt   <= '0;
        lo_cnt   <= '0;
        hs_armed <= 1'b1;
        if (hs_armed && (hi_cnt != lo_cnt))
          hs_pol <= (hi_cnt < lo_cnt);
      end else if (ce_pix) begin
        if (HSync) begin
          if (hi_cnt != HCNT_MAX)
            hi_cnt <= hi_cnt + 1'b1;
        end else if (lo_cnt != HCNT_MAX) begin
          lo_cnt <= lo_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vs_prev  <= 1'b0;
      vs_armed <= 1'b0;
      vs_pol   <= 1'b0;
      vhi_cnt  <= '0;
      vlo_cnt  <= '0;
    end else begin
      vs_prev <= VSync;
      if (vs_rise) begin
        vhi_cnt  <= '0;
        vlo_cnt  <= '0;
        vs_armed <= 1'b1;
        if (vs_armed && (vhi_cnt != vlo_cnt))
          vs_pol <= (vhi_cnt < vlo_cnt);
      end else if (hs_rise) begin
        if (VSync) begin
          if (vhi_cnt != VCNT_MAX)
            vhi_cnt <= vhi_cnt + 1'b1;
        end else if (vlo_cnt != VCNT_MAX) begin
          vlo_cnt <= vlo_cnt + 1'b1;
        end
      end
    end
  end

  logic blank, hs_act, vs_act;

  assign blank  = d_hb | d_vb;
  assign hs_act = ~(d_hs ^ hs_pol);
  assign vs_act = ~(d_vs ^ vs_pol);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_DE <= 1'b0;
    end else begin
      VGA_R  <= blank ? '0 : R;
      VGA_G  <= blank ? '0 : G;
      VGA_B  <= blank ? '0 : B;
      VGA_DE <= ~blank;
      if (csync_en) begin
        VGA_HS <= ~(hs_act | vs_act);
        VGA_VS <= 1'b1;
      end else begin
        VGA_HS <= ~hs_act;
        VGA_VS <= ~vs_act;
      end
    end
  end

endmodule

// File: tb/tb_mist_video_outstage.sv
// Directed bench for mist_video_outstage: reset, blanking, sync latency and
// polarity detection, composite sync and counter saturation.
module tb_mist_video_outstage;

  localparam int CD = 6;
  localparam int SD = 3;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_pix;
  logic [CD-1:0] R, G, B;
  logic          HSync, VSync, HBlank, VBlank, csync_en;
  logic [CD-1:0] VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_DE, hs_pol, vs_pol;

  int errors;
  int checks;

  // input history: bit [k] holds the value sampled k edges ago
  logic [SD:0] hs_q, vs_q;

  mist_video_outstage #(
    .COLOR_DEPTH(CD), .SYNC_DELAY(SD), .HCNT_WIDTH(12), .VCNT_WIDTH(11)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .R(R), .G(G), .B(B),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .csync_en(csync_en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .hs_pol(hs_pol), .vs_pol(vs_pol)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys);
      hs_q = {hs_q[SD-1:0], HSync};
      vs_q = {vs_q[SD-1:0], VSync};
      #1;
    end
  endtask

  // called #1 after reset release: reset value, SD black cycles, then live
  task automatic refill(input logic [CD-1:0] er);
    #1;
    chk("refill_de_0", VGA_DE, 0);
    chk("refill_r_0", VGA_R, 0);
    for (int k = 0; k < SD; k++) begin
      tick(1);
      chk("refill_de_k", VGA_DE, 0);
      chk("refill_r_k", VGA_R, 0);
    end
    tick(1);
    chk("refill_de_on", VGA_DE, 1);
    chk("refill_r_on", VGA_R, er);
  endtask

  task automatic hline(input int sync_len, input int total, input logic act_hi,
                       output int lows, output int first_low);
    lows = 0;
    first_low = -1;
    for (int i = 0; i < total; i++) begin
      HSync = (i < sync_len) ? act_hi : ~act_hi;
      tick(1);
      if (VGA_HS === 1'b0) begin
        if (first_low < 0) first_low = i;
        lows++;
      end
    end
  endtask

  // 30 lines of 40 pixels, 4-pixel active-high hsync at line start
  task automatic frame(input int vlines, input logic v_hi, input logic chk_en,
                       input logic hp, input logic vp, input string tag);
    int bad;
    logic ha, va, ehs, evs;
    bad = 0;
    for (int l = 0; l < 30; l++) begin
      for (int i = 0; i < 40; i++) begin
        HSync = (i < 4);
        VSync = (l < vlines) ? v_hi : ~v_hi;
        tick(1);
        ha  = ~(hs_q[SD] ^ hp);
        va  = ~(vs_q[SD] ^ vp);
        ehs = csync_en ? ~(ha | va) : ~ha;
        evs = csync_en ? 1'b1 : ~va;
        if (VGA_HS !== ehs || VGA_VS !== evs) bad++;
      end
    end
    if (chk_en) chk(tag, bad, 0);
  endtask

  // rising edge (checks the decision it makes), h-1 counted high cycles, l low
  task automatic seg(input int h, input int l, input logic ce_h,
                     input logic exp_pol, input string tag);
    HSync = 1'b1;
    ce_pix = 1'b1;
    tick(1);
    chk(tag, hs_pol, exp_pol);
    ce_pix = ce_h;
    tick(h - 1);
    ce_pix = 1'b1;
    HSync = 1'b0;
    tick(l);
  endtask

  initial begin
    int lows, first_low, bad;
    errors = 0;
    checks = 0;
    hs_q = '0;
    vs_q = '0;
    reset = 1'b1;
    ce_pix = 1'b1;
    R = 6'h3F; G = 6'h3F; B = 6'h3F;
    HSync = 1'b1; VSync = 1'b1; HBlank = 1'b0; VBlank = 1'b0;
    csync_en = 1'b0;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_r", VGA_R, 0);
    chk("rst_g", VGA_G, 0);
    chk("rst_b", VGA_B, 0);
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_de", VGA_DE, 0);
    chk("rst_hs_pol", hs_pol, 0);
    chk("rst_vs_pol", vs_pol, 0);
    reset = 1'b0;
    refill(6'h3F);

    // colour path has a single register of latency
    R = 6'h2A; G = 6'h15; B = 6'h01;
    tick(1);
    chk("color_lat_r", VGA_R, 6'h2A);
    chk("color_lat_g", VGA_G, 6'h15);
    chk("color_lat_b", VGA_B, 6'h01);
    R = 6'h3F; G = 6'h3F; B = 6'h3F;
    tick(2);

    bad = 0;
    for (int j = 0; j < 26; j++) begin
      HBlank = (j < 20);
      tick(1);
      if (j >= 3 && j <= 22 && (VGA_DE !== 1'b0 || VGA_R !== 0 || VGA_G !== 0 || VGA_B !== 0))
        bad++;
      if (j == 2) chk("hblank_pre_de", VGA_DE, 1);
      if (j == 23) begin
        chk("hblank_post_de", VGA_DE, 1);
        chk("hblank_post_g", VGA_G, 6'h3F);
      end
    end
    chk("hblank_window", bad, 0);

    bad = 0;
    for (int j = 0; j < 10; j++) begin
      VBlank = (j < 5);
      tick(1);
      if (j >= 3 && j <= 7 && (VGA_DE !== 1'b0 || VGA_B !== 0)) bad++;
      if (j == 8) chk("vblank_post_de", VGA_DE, 1);
    end
    chk("vblank_window", bad, 0);

    tick(120);

    // active-low hsync, 96 of 800
    hline(96, 800, 1'b0, lows, first_low);
    hline(96, 800, 1'b0, lows, first_low);
    chk("hs_pol_lowact", hs_pol, 0);
    hline(96, 800, 1'b0, lows, first_low);
    chk("hs_width_lowact", lows, 96);
    chk("hs_start_lowact", first_low, SD);

    // switch to active-high hsync
    hline(96, 800, 1'b1, lows, first_low);
    hline(96, 800, 1'b1, lows, first_low);
    chk("hs_pol_switch_pending", hs_pol, 0);
    hline(96, 800, 1'b1, lows, first_low);
    chk("hs_pol_highact", hs_pol, 1);
    hline(96, 800, 1'b1, lows, first_low);
    chk("hs_width_highact", lows, 96);
    chk("hs_start_highact", first_low, SD);

    // composite sync, active-low vsync 2 of 30 lines
    csync_en = 1'b1;
    frame(2, 1'b0, 1'b1, 1'b1, 1'b0, "csync_frame1");
    frame(2, 1'b0, 1'b1, 1'b1, 1'b0, "csync_frame2");
    chk("vs_pol_lowact", vs_pol, 0);

    // separate syncs, vsync switches to active-high
    csync_en = 1'b0;
    frame(2, 1'b1, 1'b0, 1'b1, 1'b0, "");
    frame(2, 1'b1, 1'b0, 1'b1, 1'b0, "");
    chk("vs_pol_switch_pending", vs_pol, 0);
    frame(2, 1'b1, 1'b0, 1'b1, 1'b1, "");
    chk("vs_pol_highact", vs_pol, 1);
    frame(2, 1'b1, 1'b1, 1'b1, 1'b1, "sep_frame_highact");
    chk("hs_pol_after_frames", hs_pol, 1);

    // saturation, ce gating, equal-count hold, clear-wins
    seg(5000, 1000, 1'b1, 1'b1, "seg_short_line");
    seg(11, 50, 1'b1, 1'b0, "seg_saturated");
    seg(101, 50, 1'b0, 1'b1, "seg_10_vs_50");
    seg(51, 50, 1'b1, 1'b1, "seg_ce_gated");
    seg(81, 50, 1'b1, 1'b1, "seg_equal_hold");
    seg(11, 50, 1'b1, 1'b0, "seg_80_vs_50");
    seg(5, 5, 1'b1, 1'b1, "seg_10_vs_50b");

    // asynchronous mid-line reset
    reset = 1'b1;
    #1;
    chk("arst_r", VGA_R, 0);
    chk("arst_hs", VGA_HS, 1);
    chk("arst_vs", VGA_VS, 1);
    chk("arst_de", VGA_DE, 0);
    chk("arst_hs_pol", hs_pol, 0);
    chk("arst_vs_pol", vs_pol, 0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    refill(6'h3F);
    seg(11, 50, 1'b1, 1'b0, "first_rise_arms_only");
    seg(1, 1, 1'b1, 1'b1, "second_rise_decides");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
